// File: rtl/johnson_code_checker_if.sv
// Bus between a Johnson-code source and its checker.
// The source drives code/code_vld; the checker returns the decoded index and status.
interface johnson_code_checker_if #(
    parameter int WIDTH = 4
);
    localparam int IDX_W = $clog2(2 * WIDTH);

    logic [WIDTH-1:0] code;
    logic             code_vld;
    logic [IDX_W-1:0] index;
    logic             index_vld;
    logic             locked;
    logic             code_err;
    logic             seq_err;
    logic [7:0]       err_count;

    modport master (
        output code, code_vld,
        input  index, index_vld, locked, code_err, seq_err, err_count
    );

    modport slave (
        input  code, code_vld,
        output index, index_vld, locked, code_err, seq_err, err_count
    );
endinterface

// File: rtl/johnson_code_checker.sv
// Johnson-code checker: decodes a twisted-ring code, flags illegal/out-of-order samples
// and tracks lock. Optional saturating error counter enabled by JCHK_ERR_COUNT_EN.
module johnson_code_checker #(
    parameter  int WIDTH      = 4,
    parameter  int LOCK_COUNT = 3,
    localparam int IDX_W      = $clog2(2 * WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    johnson_code_checker_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             index_vld_q, index_vld_d;
    logic             locked_q, locked_d;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;

    logic [WIDTH-2:0] trans;
    logic [CNT_W-1:0] pop;
    logic [CNT_W-1:0] trans_cnt;
    logic             code_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;

    // A bit transition between neighbouring positions; a legal code has at most one.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_trans
            assign trans[gi] = bus.code[gi] ^ bus.code[gi+1];
        end
    endgenerate

    always_comb begin
        pop       = '0;
        trans_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CNT_W'(bus.code[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            trans_cnt = trans_cnt + CNT_W'(trans[i]);
        end
    end

    assign code_legal = (trans_cnt <= CNT_W'(1));

    // Ones fill from the MSB for the first half of the ring, then drain from the MSB.
    always_comb begin
        if (bus.code == '0) begin
            dec_idx = '0;
        end else if (bus.code[WIDTH-1]) begin
            dec_idx = IDX_W'(pop);
        end else begin
            dec_idx = IDX_W'(2 * WIDTH - int'(pop));
        end
    end

    // The last legal index doubles as the previous sample for successor checking.
    assign succ_idx = (index_q == IDX_W'(2 * WIDTH - 1)) ? '0 : index_q + 1'b1;
    assign is_succ  = (dec_idx == succ_idx);

    // run_q counts correct successors seen since the last (re)acquisition point.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        index_d     = index_q;
        index_vld_d = 1'b0;
        code_err_d  = 1'b0;
        seq_err_d   = 1'b0;

        if (bus.code_vld) begin
            if (!code_legal) begin
                code_err_d = 1'b1;
                state_d    = UNLOCKED;
                run_d      = '0;
            end else begin
                index_d     = dec_idx;
                index_vld_d = 1'b1;
                unique case (state_q)
                    UNLOCKED: begin
                        state_d = ACQUIRE;
                        run_d   = '0;
                    end
                    ACQUIRE: begin
                        if (is_succ) begin
                            if (int'(run_q) + 1 >= LOCK_COUNT) begin
                                state_d = LOCKED;
                                run_d   = '0;
                            end else begin
                                run_d = run_q + 1'b1;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            run_d     = '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_succ) begin
                            seq_err_d = 1'b1;
                            state_d   = ACQUIRE;
                            run_d     = '0;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        run_d   = '0;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            run_q       <= '0;
            index_q     <= '0;
            index_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            code_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            index_q     <= index_d;
            index_vld_q <= index_vld_d;
            locked_q    <= locked_d;
            code_err_q  <= code_err_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.index     = index_q;
    assign bus.index_vld = index_vld_q;
    assign bus.locked    = locked_q;
    assign bus.code_err  = code_err_q;
    assign bus.seq_err   = seq_err_q;

`ifdef JCHK_ERR_COUNT_EN
    logic [7:0] err_count_q;

    // Counts in step with the error pulses so the count and the pulse appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else if ((code_err_d || seq_err_d) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_johnson_code_checker.sv
// Directed plus randomized check of johnson_code_checker against a table-driven ring model.
// Covers both builds of the JCHK_ERR_COUNT_EN option.
module tb_johnson_code_checker;
    localparam int W  = 4;
    localparam int N2 = 2 * W;
    localparam int LC = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    johnson_code_checker_if #(.WIDTH(W)) bus ();

    johnson_code_checker #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] ring [N2];

    // Behavioural model state
    int m_index, m_succ, m_cnt;
    bit m_vld, m_locked, m_cerr, m_serr, m_active;

    function automatic int lookup(logic [W-1:0] c);
        for (int k = 0; k < N2; k++) if (ring[k] == c) return k;
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_illegal();
        logic [W-1:0] c;
        for (int t = 0; t < 100; t++) begin
            c = W'($urandom);
            if (lookup(c) < 0) return c;
        end
        c = 4'b1010;
        return c;
    endfunction

    task automatic model_reset();
        m_index = 0; m_succ = 0; m_cnt = 0;
        m_vld = 0; m_locked = 0; m_cerr = 0; m_serr = 0; m_active = 0;
    endtask

    task automatic model_update(logic [W-1:0] c, logic v);
        int k;
        m_vld = 0; m_cerr = 0; m_serr = 0;
        if (v) begin
            k = lookup(c);
            if (k < 0) begin
                m_cerr = 1; m_active = 0; m_locked = 0; m_succ = 0;
            end else begin
                m_vld = 1;
                if (!m_active) begin
                    m_active = 1; m_succ = 0;
                end else if (k == (m_index + 1) % N2) begin
                    m_succ++;
                    if (m_succ >= LC) m_locked = 1;
                end else begin
                    m_serr = 1; m_succ = 0; m_locked = 0;
                end
                m_index = k;
            end
`ifdef JCHK_ERR_COUNT_EN
            if ((m_cerr || m_serr) && m_cnt < 255) m_cnt++;
`endif
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".index"},     32'(bus.index),     32'(m_index));
        check({tag, ".index_vld"}, 32'(bus.index_vld), 32'(m_vld));
        check({tag, ".locked"},    32'(bus.locked),    32'(m_locked));
        check({tag, ".code_err"},  32'(bus.code_err),  32'(m_cerr));
        check({tag, ".seq_err"},   32'(bus.seq_err),   32'(m_serr));
        check({tag, ".err_count"}, 32'(bus.err_count), 32'(m_cnt));
    endtask

    task automatic step(logic [W-1:0] c, logic v, string tag);
        @(negedge clk);
        bus.code     = c;
        bus.code_vld = v;
        @(posedge clk);
        #1;
        model_update(c, v);
        check_all(tag);
        $display("%s code=%b vld=%0b -> idx=%0d ivld=%0b lck=%0b cerr=%0b serr=%0b cnt=%0d",
                 tag, c, v, bus.index, bus.index_vld, bus.locked, bus.code_err,
                 bus.seq_err, bus.err_count);
    endtask

    initial begin
        int r;
        logic [W-1:0] c;

        for (int k = 0; k < N2; k++) begin
            c = '0;
            if (k <= W) begin
                for (int b = 0; b < k; b++) c[W-1-b] = 1'b1;
            end else begin
                for (int b = 0; b < N2 - k; b++) c[b] = 1'b1;
            end
            ring[k] = c;
        end

        // Reset
        rst_n = 1'b0;
        bus.code = '0;
        bus.code_vld = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full ring, lock after third correct successor
        for (int k = 0; k <= N2; k++) begin
            step(ring[k % N2], 1'b1, "t1_ring");
            if (k == 2) check("t1_not_locked_yet", 32'(bus.locked), 32'd0);
            if (k == 3) check("t1_locked_4th", 32'(bus.locked), 32'd1);
        end

        // 2: illegal code while locked, then relock
        step(4'b1010, 1'b1, "t2_illegal");
        check("t2_code_err", 32'(bus.code_err), 32'd1);
        check("t2_index_hold", 32'(bus.index), 32'd0);
        step(4'b0011, 1'b1, "t2_resume");
        step(4'b0001, 1'b1, "t2_resume");
        step(4'b0000, 1'b1, "t2_resume");
        step(4'b1000, 1'b1, "t2_resume");
        check("t2_relocked", 32'(bus.locked), 32'd1);

        // 3: wrong legal successor from index 2
        step(4'b1100, 1'b1, "t3_at2");
        step(4'b0111, 1'b1, "t3_jump");
        check("t3_seq_err", 32'(bus.seq_err), 32'd1);
        check("t3_index5", 32'(bus.index), 32'd5);
        step(4'b0011, 1'b1, "t3_resume");
        step(4'b0001, 1'b1, "t3_resume");
        step(4'b0000, 1'b1, "t3_resume");
        check("t3_relocked", 32'(bus.locked), 32'd1);

        // 4: gaps in code_vld, then a repeated code
        step(ring[1], 1'b1, "t4_gap");
        step(4'b1010, 1'b0, "t4_gap");
        step(ring[2], 1'b1, "t4_gap");
        step(4'b0101, 1'b0, "t4_gap");
        step(ring[3], 1'b1, "t4_gap");
        step(ring[4], 1'b1, "t4_gap");
        step(ring[4], 1'b1, "t4_repeat");
        check("t4_repeat_seq_err", 32'(bus.seq_err), 32'd1);

        // 5: get locked, then asynchronous reset between edges
        step(ring[5], 1'b1, "t5_pre");
        step(ring[6], 1'b1, "t5_pre");
        step(ring[7], 1'b1, "t5_pre");
        check("t5_locked_before", 32'(bus.locked), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_async_index",  32'(bus.index),  32'd0);
        check("t5_async_locked", 32'(bus.locked), 32'd0);
        check_all("t5_async");
        bus.code_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(ring[5], 1'b1, "t5_after");
        check("t5_no_seq_err", 32'(bus.seq_err), 32'd0);

        // 6: many illegal samples saturate the counter when enabled
        for (int i = 0; i < 300; i++) step(rand_illegal(), 1'b1, "t6_illegal");
`ifdef JCHK_ERR_COUNT_EN
        check("t6_saturated", 32'(bus.err_count), 32'd255);
`else
        check("t6_tied_zero", 32'(bus.err_count), 32'd0);
`endif

        // Random mix against the model
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      step(ring[(m_index + 1) % N2], 1'b1, "rnd_succ");
            else if (r == 6) step(ring[$urandom_range(0, N2 - 1)], 1'b1, "rnd_legal");
            else if (r == 7) step(rand_illegal(), 1'b1, "rnd_illegal");
            else if (r == 8) step(W'($urandom), 1'b0, "rnd_idle");
            else             step(ring[m_index], 1'b1, "rnd_repeat");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
